// File: rtl/ama_riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select
// encodings, the bubble instruction and the default reset PC.
package ama_riscv_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEL_START_ADDR = 2'd0,
        PC_SEL_INC4       = 2'd1,
        PC_SEL_ALU        = 2'd2,
        PC_SEL_RSVD       = 2'd3
    } pc_sel_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] START_ADDR = 32'h0000_0000;

    // Jump/branch targets are forced onto a word boundary; bit 1 is only
    // reported through the sticky misalignment flag.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ama_riscv_next_pc.sv
// Next-PC selection mux together with the shared pc + 4 adder.
module ama_riscv_next_pc #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    output logic [31:0] next_pc,
    output logic [31:0] pc_inc4
);
    import ama_riscv_fetch_pkg::*;

    // pc + 4 wraps naturally at 2^32
    always_comb begin
        pc_inc4 = pc + 32'd4;
    end

    // Reserved encoding holds the PC rather than flagging an error
    always_comb begin
        next_pc = pc;
        case (pc_sel_t'(pc_sel))
            PC_SEL_START_ADDR: next_pc = START_ADDR;
            PC_SEL_INC4:       next_pc = pc_inc4;
            PC_SEL_ALU:        next_pc = word_align(alu_out);
            default:           next_pc = pc;
        endcase
    end

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM and
// presents an aligned (pc_id, inst_id) pair to decode, replacing the
// instruction with a NOP for the cycle after reset, stall or clear.
module ama_riscv_fetch #(
    parameter logic [31:0] START_ADDR = ama_riscv_fetch_pkg::START_ADDR,
    parameter int          IMEM_AW    = 14,
    parameter logic [31:0] NOP_INST   = ama_riscv_fetch_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_sel,
    input  logic               pc_we,
    input  logic               stall_if,
    input  logic               clear_if,
    input  logic [31:0]        alu_out,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_id,
    output logic [31:0]        pc_inc4_id,
    output logic [31:0]        inst_id,
    output logic               inst_valid_id,
    output logic               fetch_misaligned
);
    import ama_riscv_fetch_pkg::*;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] pc_inc4;
    logic [31:0] fetch_addr;
    logic        rst_q;
    logic        stall_q;
    logic        clear_q;
    logic        bubble;
    logic        misaligned_q;

    ama_riscv_next_pc #(
        .START_ADDR (START_ADDR)
    ) u_next_pc (
        .pc_sel  (pc_sel),
        .pc      (pc),
        .alu_out (alu_out),
        .next_pc (next_pc),
        .pc_inc4 (pc_inc4)
    );

    // PC register: reload on reset, otherwise advance only when decode allows
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= START_ADDR;
        end else if (pc_we) begin
            pc <= next_pc;
        end
    end

    // IMEM is addressed with the value the PC is about to take, so the
    // registered read data always lines up with pc one cycle later
    always_comb begin
        if (rst) begin
            fetch_addr = START_ADDR;
        end else if (pc_we) begin
            fetch_addr = next_pc;
        end else begin
            fetch_addr = pc;
        end
        imem_addr = fetch_addr[IMEM_AW+1:2];
        imem_en   = rst | pc_we;
    end

    // Bubble flags: each marks the next ID cycle as a NOP; reset drops any
    // pending stall/clear so only the single post-reset bubble remains
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            stall_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            stall_q <= stall_if;
            clear_q <= clear_if;
        end
    end

    // Sticky record of an accepted jump target with bit 1 set
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else if (pc_we && (pc_sel == PC_SEL_ALU) && alu_out[1]) begin
            misaligned_q <= 1'b1;
        end
    end

    // ID outputs: substitute the NOP whenever a bubble is pending
    always_comb begin
        bubble           = rst_q | stall_q | clear_q;
        inst_id          = bubble ? NOP_INST : imem_rdata;
        inst_valid_id    = ~bubble;
        pc_id            = pc;
        pc_inc4_id       = pc_inc4;
        fetch_misaligned = misaligned_q;
    end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: directed scenarios followed by random
// stimulus, compared each cycle against a behavioural fetch model.
module tb_ama_riscv_fetch;

    localparam int          IMEM_AW = 14;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] START   = 32'h0000_0000;

    logic               clk;
    logic               rst;
    logic [1:0]         pc_sel;
    logic               pc_we;
    logic               stall_if;
    logic               clear_if;
    logic [31:0]        alu_out;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        pc_id;
    logic [31:0]        pc_inc4_id;
    logic [31:0]        inst_id;
    logic               inst_valid_id;
    logic               fetch_misaligned;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:(1<<IMEM_AW)-1];

    // reference state: what the stage should present after the last edge
    logic [31:0] m_pc;
    logic        m_bubble;
    logic        m_mis;

    ama_riscv_fetch #(
        .START_ADDR (START),
        .IMEM_AW    (IMEM_AW),
        .NOP_INST   (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_sel           (pc_sel),
        .pc_we            (pc_we),
        .stall_if         (stall_if),
        .clear_if         (clear_if),
        .alu_out          (alu_out),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .pc_id            (pc_id),
        .pc_inc4_id       (pc_inc4_id),
        .inst_id          (inst_id),
        .inst_valid_id    (inst_valid_id),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous IMEM with one-cycle read latency, holds when not enabled
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] s, input logic [31:0] pc,
                                                input logic [31:0] a);
        case (s)
            2'd0:    return START;
            2'd1:    return pc + 32'd4;
            2'd2:    return a & 32'hFFFF_FFFC;
            default: return pc;
        endcase
    endfunction

    // One cycle: drive at the falling edge, check IMEM request, let the
    // edge happen, update the model, then check the ID-facing outputs.
    task automatic cyc(input logic r, input logic [1:0] s, input logic w, input logic st,
                       input logic cl, input logic [31:0] a);
        logic [31:0] target;
        logic [31:0] exp_inst;
        rst = r; pc_sel = s; pc_we = w; stall_if = st; clear_if = cl; alu_out = a;
        #1;
        target = r ? START : (w ? model_next(s, m_pc, a) : m_pc);
        check("imem_en", {31'd0, imem_en}, {31'd0, r | w});
        check("imem_addr", {18'd0, imem_addr}, {18'd0, target[IMEM_AW+1:2]});
        @(posedge clk);
        m_bubble = r | st | cl;
        m_mis    = r ? 1'b0 : (m_mis | (w && s == 2'd2 && a[1]));
        m_pc     = target;
        @(negedge clk);
        exp_inst = m_bubble ? NOP : mem[m_pc[IMEM_AW+1:2]];
        check("pc_id", pc_id, m_pc);
        check("pc_inc4_id", pc_inc4_id, m_pc + 32'd4);
        check("inst_id", inst_id, exp_inst);
        check("inst_valid_id", {31'd0, inst_valid_id}, {31'd0, ~m_bubble});
        check("fetch_misaligned", {31'd0, fetch_misaligned}, {31'd0, m_mis});
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'hC0DE_0000 ^ i;
        m_pc = START; m_bubble = 1'b1; m_mis = 1'b0;
        rst = 1'b1; pc_sel = 2'd0; pc_we = 1'b0; stall_if = 1'b0; clear_if = 1'b0;
        alu_out = 32'd0;
        @(negedge clk);

        // reset exit and sequential fetch
        for (int i = 0; i < 3; i++) cyc(1, 2'd0, 0, 0, 0, 32'd0);
        cyc(0, 2'd0, 1, 0, 0, 32'd0);
        for (int i = 0; i < 8; i++) cyc(0, 2'd1, 1, 0, 0, 32'd0);

        // stall with PC held, then resume
        for (int i = 0; i < 2; i++) cyc(0, 2'd1, 0, 1, 0, 32'd0);
        cyc(0, 2'd1, 0, 0, 0, 32'd0);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);

        // misaligned jump with flush
        cyc(0, 2'd2, 1, 0, 1, 32'h0000_0103);
        cyc(0, 2'd1, 0, 0, 0, 32'd0);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);

        // wrap-around and reserved select
        cyc(0, 2'd2, 1, 0, 0, 32'hFFFF_FFFC);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);
        cyc(0, 2'd3, 1, 0, 0, 32'h0000_0800);
        cyc(0, 2'd1, 1, 1, 1, 32'd0);

        // reset in the middle of a stall with a flush pending
        cyc(0, 2'd1, 0, 1, 0, 32'd0);
        cyc(1, 2'd2, 1, 1, 1, 32'h0000_0402);
        cyc(0, 2'd0, 1, 0, 0, 32'd0);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);
        cyc(0, 2'd1, 1, 0, 0, 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            cyc(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0), a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
